// File: rtl/comp_pkg.sv
// Shared constants for the serial magnitude comparator: FSM state codes and slice width.
package comp_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/comp_8.sv
// 8-bit cascadable magnitude comparator slice; EQ1/GT1 carry the verdict of more significant bits.
module comp_8 (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       EQ1,
    input  logic       GT1,
    output logic       EQ0,
    output logic       GT0
);

    // A decided upper verdict passes straight through; only a tie so far lets this byte vote
    assign EQ0 = EQ1 & (A == B);
    assign GT0 = GT1 | (EQ1 & (A > B));

endmodule

// File: rtl/serial_comp_32.sv
// Multi-cycle unsigned comparator that walks the operands MSB byte first through one comp_8 slice.
module serial_comp_32
    import comp_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             EQ,
    output logic             GT,
    output logic             LT
);

    localparam int N  = WIDTH / BYTE_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t             state;
    state_t             nextState;
    logic [WIDTH-1:0]   aReg;
    logic [WIDTH-1:0]   bReg;
    logic [CW-1:0]      count;
    logic               ceq;
    logic               cgt;
    logic               eq0;
    logic               gt0;
    logic [BYTE_W-1:0]  aByte;
    logic [BYTE_W-1:0]  bByte;
    logic               finish;

    assign aByte = aReg[BYTE_W*int'(count) +: BYTE_W];
    assign bByte = bReg[BYTE_W*int'(count) +: BYTE_W];

    comp_8 slice (
        .A   (aByte),
        .B   (bByte),
        .EQ1 (ceq),
        .GT1 (cgt),
        .EQ0 (eq0),
        .GT0 (gt0)
    );

    // Last byte reached, or with early exit the first differing byte already settles the verdict
    assign finish = (count == '0) || (EARLY_EXIT && !eq0);

    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = IDLE;
        case (state)
            IDLE:    nextState = start ? RUN : IDLE;
            RUN:     nextState = finish ? DONE : RUN;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Results take the slice outputs directly so the final byte is included on the edge into DONE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aReg  <= '0;
            bReg  <= '0;
            count <= '0;
            ceq   <= 1'b1;
            cgt   <= 1'b0;
            EQ    <= 1'b0;
            GT    <= 1'b0;
            LT    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        aReg  <= A;
                        bReg  <= B;
                        ceq   <= 1'b1;
                        cgt   <= 1'b0;
                        count <= LAST;
                    end
                end
                RUN: begin
                    ceq <= eq0;
                    cgt <= gt0;
                    if (finish) begin
                        EQ <= eq0;
                        GT <= gt0;
                        LT <= ~eq0 & ~gt0;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
